adder_txn_driver: RTL and testbench

//  Synthesizable transaction initiator for the adder DUT interface.
//  - Queues operand/opcode requests and drives them onto the DUT's a/b/opcode pins one at a time.
//  - Waits the DUT latency, then captures c.
//  - Returns c, plus an optional pass/fail flag, on a valid/ready response channel.
//  - Sits between a host/sequence source and the adder, as the hardware counterpart of the bench driver/monitor.

---
 rtl/adder_txn_driver.sv | 155 +++++++++++++++
 tb/tb_adder_txn_driver.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_txn_driver.sv
// Transaction initiator for the adder DUT: queues requests, drives them one at a time, captures c.
// Define ADDER_TXN_CHECK_EN to store expected results and flag/count mismatches.
module adder_txn_driver #(
  parameter int DATA_W     = 4,
  parameter int RES_W      = 5,
  parameter int DUT_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic              req_op,
  output logic [DATA_W-1:0] dut_a,
  output logic [DATA_W-1:0] dut_b,
  output logic              dut_opcode,
  input  logic [RES_W-1:0]  dut_c,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_c,
  output logic              rsp_err,
  output logic [7:0]        err_count,
  output logic              busy
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_lat_cnt;
  logic [AW:0]        r_wr_ptr;
  logic [AW:0]        r_rd_ptr;
  logic [DATA_W-1:0]  r_mem_a  [FIFO_DEPTH];
  logic [DATA_W-1:0]  r_mem_b  [FIFO_DEPTH];
  logic               r_mem_op [FIFO_DEPTH];

  logic [AW:0]        w_count;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [AW-1:0]      w_rd_idx;
  logic [AW-1:0]      w_wr_idx;

  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign w_full    = (w_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_rd_idx  = r_rd_ptr[AW-1:0];
  assign w_wr_idx  = r_wr_ptr[AW-1:0];
  // Ready depends only on the registered count, so a pop cannot re-open it in the same cycle.
  assign req_ready = !w_full;
  assign w_push    = req_valid && !w_full;
  assign w_pop     = (r_state == S_IDLE) && !w_empty;
  assign busy      = (r_state != S_IDLE) || !w_empty;

`ifdef ADDER_TXN_CHECK_EN
  logic [RES_W-1:0] r_mem_exp [FIFO_DEPTH];
  logic [RES_W-1:0] r_exp_cur;
  logic [RES_W-1:0] w_exp;

  assign w_exp = req_op ? (RES_W'(req_a) - RES_W'(req_b)) : (RES_W'(req_a) + RES_W'(req_b));

  always_ff @(posedge clk) begin
    if (w_push) r_mem_exp[w_wr_idx] <= w_exp;
  end
`else
  assign rsp_err   = 1'b0;
  assign err_count = '0;
`endif

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[w_wr_idx]  <= req_a;
      r_mem_b[w_wr_idx]  <= req_b;
      r_mem_op[w_wr_idx] <= req_op;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_lat_cnt  <= '0;
      dut_a      <= '0;
      dut_b      <= '0;
      dut_opcode <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_c      <= '0;
`ifdef ADDER_TXN_CHECK_EN
      r_exp_cur  <= '0;
      rsp_err    <= 1'b0;
      err_count  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            dut_a      <= r_mem_a[w_rd_idx];
            dut_b      <= r_mem_b[w_rd_idx];
            dut_opcode <= r_mem_op[w_rd_idx];
`ifdef ADDER_TXN_CHECK_EN
            r_exp_cur  <= r_mem_exp[w_rd_idx];
`endif
            r_state    <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          r_lat_cnt <= CNT_W'(DUT_LAT - 1);
          r_state   <= (DUT_LAT == 1) ? S_CAPTURE : S_WAIT;
        end
        S_WAIT: begin
          // Leave as the counter reaches zero, keeping capture DUT_LAT+1 edges after the drive edge.
          r_lat_cnt <= r_lat_cnt - CNT_W'(1);
          if (r_lat_cnt <= CNT_W'(1)) r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          rsp_c     <= dut_c;
          rsp_valid <= 1'b1;
`ifdef ADDER_TXN_CHECK_EN
          rsp_err   <= (dut_c != r_exp_cur);
          if ((dut_c != r_exp_cur) && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
`endif
          r_state   <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_txn_driver.sv
// Self-checking bench for adder_txn_driver with a behavioural adder and a queue-based reference model.
module tb_adder_txn_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic       req_op;
  logic [3:0] dut_a;
  logic [3:0] dut_b;
  logic       dut_opcode;
  logic [4:0] dut_c;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [4:0] rsp_c;
  logic       rsp_err;
  logic [7:0] err_count;
  logic       busy;

  logic [4:0] r_gold_c;
  logic       r_c_zero = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  int m_err = 0;

  typedef struct {
    int a;
    int b;
    int op;
  } txn_t;
  txn_t q[$];

  always #5 clk = ~clk;

  adder_txn_driver #(
    .DATA_W(4), .RES_W(5), .DUT_LAT(1), .FIFO_DEPTH(4)
  ) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .dut_a(dut_a), .dut_b(dut_b), .dut_opcode(dut_opcode), .dut_c(dut_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c),
    .rsp_err(rsp_err), .err_count(err_count), .busy(busy)
  );

  // Golden adder with one cycle of latency; r_c_zero models a broken DUT output.
  always @(posedge clk) begin
    int s;
    s = dut_opcode ? (int'(dut_a) - int'(dut_b)) : (int'(dut_a) + int'(dut_b));
    r_gold_c <= 5'(s & 31);
  end
  assign dut_c = r_c_zero ? 5'd0 : r_gold_c;

  function automatic int ref_res(input txn_t t);
    int r;
    r = (t.op != 0) ? t.a - t.b : t.a + t.b;
    return r & 31;
  endfunction

  task automatic check(input string tag, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push(input int a, input int b, input int op);
    int cyc;
    txn_t t;
    cyc = 0;
    req_valid = 1'b1;
    req_a = 4'(a);
    req_b = 4'(b);
    req_op = 1'(op);
    while (!req_ready) begin
      @(negedge clk);
      cyc++;
      if (cyc > 200) begin
        check("push_timeout", 0, 1);
        req_valid = 1'b0;
        return;
      end
    end
    @(negedge clk);
    t.a = a; t.b = b; t.op = op;
    q.push_back(t);
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(input bit rnd);
    int cyc;
    bit done;
    txn_t t;
    int e;
    bit ex_err;
    cyc = 0;
    done = 1'b0;
    while (!done) begin
      rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rsp_valid && rsp_ready) begin
        done = 1'b1;
        if (q.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          t = q.pop_front();
          e = r_c_zero ? 0 : ref_res(t);
`ifdef ADDER_TXN_CHECK_EN
          ex_err = (e != ref_res(t));
          if (ex_err && m_err < 255) m_err++;
`else
          ex_err = 1'b0;
`endif
          check("rsp_c", rsp_c, e);
          check("rsp_err", rsp_err, ex_err);
          check("err_count", err_count, m_err);
        end
      end
      @(negedge clk);
      cyc++;
      if (!done && cyc > 200) begin
        check("rsp_timeout", 0, 1);
        done = 1'b1;
      end
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    int exp_first;
    bit seen;
    reset = 1'b1;
    req_valid = 1'b0; req_a = '0; req_b = '0; req_op = 1'b0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_dut_a", dut_a, 0);
    check("rst_dut_b", dut_b, 0);
    check("rst_dut_op", dut_opcode, 0);
    check("rst_err_count", err_count, 0);
    check("rst_busy", busy, 0);

    // Single add: pop on the edge after the push, response two edges later.
    push(7, 9, 0);
    @(negedge clk);
    check("drv_a", dut_a, 7);
    check("drv_b", dut_b, 9);
    check("lat_early1", rsp_valid, 0);
    @(negedge clk);
    check("lat_early2", rsp_valid, 0);
    @(negedge clk);
    check("lat_valid", rsp_valid, 1);
    get_rsp(0);

    push(3, 5, 1);
    get_rsp(0);

    // Back-pressure: one in flight plus four queued fills everything.
    for (int i = 0; i < 5; i++) push(i + 1, 2 * i, i % 2);
    check("full_ready", req_ready, 0);
    check("full_busy", busy, 1);
    req_valid = 1'b1; req_a = 4'd15; req_b = 4'd15; req_op = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_ready", req_ready, 0);
    end
    t = q[0];
    exp_first = ref_res(t);
    repeat (10) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_c", rsp_c, exp_first);
    end
    fork
      push(15, 15, 0);
      repeat (6) get_rsp(0);
    join
    check("drain_busy", busy, 0);

    // Random traffic with random response back-pressure.
    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        push($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
      end
      repeat (40) get_rsp(1);
    join

    // Corrupted DUT output and counter saturation.
    r_c_zero = 1'b1;
    push(1, 1, 0);
    get_rsp(0);
    for (int i = 0; i < 300; i++) begin
      push($urandom_range(1, 15), $urandom_range(0, 15), 0);
      get_rsp(0);
    end
`ifdef ADDER_TXN_CHECK_EN
    check("err_sat", err_count, 255);
`else
    check("err_sat", err_count, 0);
`endif
    r_c_zero = 1'b0;

    // Reset with one transaction in flight and three queued.
    for (int i = 0; i < 4; i++) push(i + 2, i, 0);
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    q.delete();
    m_err = 0;
    @(negedge clk);
    check("mrst_rsp_valid", rsp_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_req_ready", req_ready, 1);
    check("mrst_err_count", err_count, 0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("mrst_no_rsp", seen, 0);
    push(2, 3, 0);
    get_rsp(0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
